// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the D-cache port arbiter and the MMU that feeds it.
package dcache_port_arbiter_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned STARVE_W = 8;

    // Arbiter sequencing: one D$ transaction in flight at a time.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } dcache_arb_state_t;

    // Which requester currently owns the D$ port.
    typedef enum logic {
        OWN_LSU  = 1'b0,
        OWN_WALK = 1'b1
    } dcache_owner_t;

    // Page-table entry permission bits as seen by the MMU.
    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } tlb_perm_bits;

    // Page-table walker states.
    typedef enum logic [1:0] {
        MMU_IDLE  = 2'd0,
        MMU_WALK  = 2'd1,
        MMU_FAULT = 2'd2
    } MMU_State;

    // Latched request payload held for the duration of a transaction.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            write;
        logic [XLEN-1:0] wdata;
        dcache_owner_t   owner;
    } dc_req_t;

endpackage

// File: rtl/dcache_port_arbiter_starve.sv
// Saturating count of arbitrations the LSU lost while it was waiting.
module arb_starve_counter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_LIMIT[STARVE_W-1:0];

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign at_limit = (cnt_q == LIMIT);

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the D-cache request port between the LSU and the page-table walker.
// The walker normally wins; the LSU wins once it has lost STARVE_LIMIT times.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lsu_req_valid,
    input  logic [XLEN-1:0] lsu_req_addr,
    input  logic            lsu_req_write,
    input  logic [XLEN-1:0] lsu_req_wdata,
    output logic            lsu_req_ready,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_resp_data,
    input  logic            walk_req,
    input  logic [XLEN-1:0] walk_req_addr,
    output logic            walk_resp_valid,
    output logic [XLEN-1:0] walk_resp_data,
    output logic            dc_req_valid,
    input  logic            dc_req_ready,
    output logic [XLEN-1:0] dc_req_addr,
    output logic            dc_req_write,
    output logic [XLEN-1:0] dc_req_wdata,
    output logic            dc_req_phys,
    input  logic            dc_resp_valid,
    input  logic [XLEN-1:0] dc_resp_data,
    output logic            arb_owner
);

    dcache_arb_state_t state_q, state_d;
    dc_req_t           req_q, req_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_at_limit;
    logic walk_wins;

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .at_limit(starve_at_limit)
    );

    // Walker has priority unless the LSU is waiting and has been starved long enough.
    assign walk_wins = walk_req && !(starve_at_limit && lsu_req_valid);

    // Next state, payload capture and all handshake outputs.
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        starve_inc      = 1'b0;
        starve_clr      = 1'b0;
        lsu_req_ready   = 1'b0;
        lsu_resp_valid  = 1'b0;
        lsu_resp_data   = '0;
        walk_resp_valid = 1'b0;
        walk_resp_data  = '0;
        dc_req_valid    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (!lsu_req_valid) begin
                    starve_clr = 1'b1;
                end
                if (walk_wins) begin
                    req_d.addr  = walk_req_addr;
                    req_d.write = 1'b0;
                    req_d.wdata = '0;
                    req_d.owner = OWN_WALK;
                    starve_inc  = lsu_req_valid;
                    state_d     = ARB_ISSUE;
                end else if (lsu_req_valid) begin
                    req_d.addr    = lsu_req_addr;
                    req_d.write   = lsu_req_write;
                    req_d.wdata   = lsu_req_wdata;
                    req_d.owner   = OWN_LSU;
                    lsu_req_ready = 1'b1;
                    starve_clr    = 1'b1;
                    state_d       = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // Held until accepted, regardless of what the requester does meanwhile.
                dc_req_valid = 1'b1;
                if (dc_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (dc_resp_valid) begin
                    state_d = ARB_IDLE;
                    if (req_q.owner == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                        lsu_resp_data  = dc_resp_data;
                    end else if (walk_req) begin
                        // A walker that gave up no longer wants this PTE.
                        walk_resp_valid = 1'b1;
                        walk_resp_data  = dc_resp_data;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Request payload is only presented while the request is live.
    assign dc_req_addr  = dc_req_valid ? req_q.addr  : '0;
    assign dc_req_write = dc_req_valid & req_q.write;
    assign dc_req_wdata = dc_req_valid ? req_q.wdata : '0;
    assign dc_req_phys  = dc_req_valid & (req_q.owner == OWN_WALK);
    assign arb_owner    = (state_q != ARB_IDLE) & (req_q.owner == OWN_WALK);

    // State and payload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench: the stimulus runs a transaction-level model of the two
// requesters and pushes expected D$ requests / responses; a monitor checks them.
module tb_dcache_port_arbiter;

    localparam int unsigned LIMIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_valid, lsu_req_write, lsu_req_ready, lsu_resp_valid;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic        walk_req, walk_resp_valid;
    logic [63:0] walk_req_addr, walk_resp_data;
    logic        dc_req_valid, dc_req_ready, dc_req_write, dc_req_phys;
    logic [63:0] dc_req_addr, dc_req_wdata;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_data;
    logic        arb_owner;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr),
        .lsu_req_write(lsu_req_write), .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_data(lsu_resp_data),
        .walk_req(walk_req), .walk_req_addr(walk_req_addr),
        .walk_resp_valid(walk_resp_valid), .walk_resp_data(walk_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_write(dc_req_write),
        .dc_req_wdata(dc_req_wdata), .dc_req_phys(dc_req_phys),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .arb_owner(arb_owner)
    );

    typedef struct packed {
        logic [63:0] a;
        logic        w;
        logic [63:0] d;
        logic        p;
    } exp_req_t;

    exp_req_t    exp_dc_q[$];
    logic [63:0] exp_lsu_q[$];
    logic [63:0] exp_walk_q[$];
    int          exp_rdy_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          done = 1'b0;
    bit          chk_zero = 1'b0;

    // Requester model
    bit          lsu_pend = 1'b0;
    logic [63:0] lsu_a, lsu_d;
    logic        lsu_w;
    bit          walk_pend = 1'b0;
    logic [63:0] walk_a;
    int          lost = 0;   // walker wins while the LSU was waiting

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic set_lsu(input logic [63:0] a, input logic w, input logic [63:0] d);
        lsu_pend = 1'b1; lsu_a = a; lsu_w = w; lsu_d = d;
    endtask

    task automatic set_walk(input logic [63:0] a);
        walk_pend = 1'b1; walk_a = a;
    endtask

    task automatic drive_reqs();
        lsu_req_valid = lsu_pend;
        lsu_req_addr  = lsu_a;
        lsu_req_write = lsu_w;
        lsu_req_wdata = lsu_d;
        walk_req      = walk_pend;
        walk_req_addr = walk_a;
    endtask

    // One arbitration opportunity; called at the negedge of an idle cycle.
    task automatic round(input bit new_lsu, input bit new_walk, input int rdy_dly,
                         input int lat, input bit walk_drop, input logic [63:0] rdata);
        bit walk_won;
        if (new_lsu && !lsu_pend) set_lsu(rand64(), 1'($urandom_range(0, 1)), rand64());
        if (new_walk && !walk_pend) set_walk(rand64() & ~64'h7);
        drive_reqs();
        if (!lsu_pend && !walk_pend) begin
            lost = 0;
            dc_resp_valid = 1'($urandom_range(0, 1));   // stray response, must be ignored
            dc_resp_data  = rand64();
            @(negedge clk);
            dc_resp_valid = 1'b0;
            return;
        end
        walk_won = walk_pend && !(lsu_pend && lost == int'(LIMIT));
        if (walk_won) begin
            exp_dc_q.push_back('{a: walk_a, w: 1'b0, d: 64'd0, p: 1'b1});
            if (!walk_drop) exp_walk_q.push_back(rdata);
            lost = lsu_pend ? lost + 1 : 0;
        end else begin
            exp_dc_q.push_back('{a: lsu_a, w: lsu_w, d: lsu_d, p: 1'b0});
            exp_lsu_q.push_back(rdata);
            exp_rdy_q.push_back(1);
            lost = 0;
        end
        @(negedge clk);
        if (!walk_won) begin
            lsu_pend = 1'b0;
            lsu_req_valid = 1'b0;
            lsu_req_addr  = rand64();
            lsu_req_wdata = rand64();
        end else if (walk_drop) begin
            walk_pend = 1'b0;
            walk_req  = 1'b0;
        end
        repeat (rdy_dly) @(negedge clk);
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0;
        repeat (lat - 1) @(negedge clk);
        dc_resp_valid = 1'b1;
        dc_resp_data  = rdata;
        @(negedge clk);
        dc_resp_valid = 1'b0;
        dc_resp_data  = rand64();
        if (walk_won) walk_pend = 1'b0;
    endtask

    // LSU transaction interrupted by reset while waiting for the D$.
    task automatic reset_in_wait();
        set_lsu(rand64(), 1'b0, 64'd0);
        drive_reqs();
        exp_dc_q.push_back('{a: lsu_a, w: 1'b0, d: 64'd0, p: 1'b0});
        exp_rdy_q.push_back(1);
        @(negedge clk);
        lsu_pend = 1'b0; lsu_req_valid = 1'b0; dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0; reset = 1'b1; chk_zero = 1'b1;
        @(negedge clk);
        reset = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = rand64();
        @(negedge clk);
        dc_resp_valid = 1'b0; chk_zero = 1'b0; lost = 0;
    endtask

    // Stimulus
    initial begin
        reset = 1'b1;
        lsu_a = '0; lsu_d = '0; lsu_w = 1'b0; walk_a = '0;
        drive_reqs();
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0; chk_zero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dc_resp_valid = (i == 4);
            dc_resp_data  = 64'h1234_5678;
            @(negedge clk);
        end
        dc_resp_valid = 1'b0; chk_zero = 1'b0;

        set_lsu(64'h8000_1000, 1'b0, 64'd0);
        round(0, 0, 0, 2, 0, 64'hDEAD_BEEF);

        set_lsu(rand64(), 1'b1, rand64());
        set_walk(64'h9000_0FF8);
        round(0, 0, 1, 1, 0, rand64());
        round(0, 0, 0, 3, 0, rand64());

        set_lsu(rand64(), 1'b0, 64'd0);
        repeat (4) round(0, 1, 0, 1, 0, rand64());
        set_lsu(rand64(), 1'b1, rand64());
        repeat (3) round(0, 1, 0, 1, 0, rand64());

        set_walk(64'h9000_2000);
        round(0, 0, 2, 3, 1, rand64());

        reset_in_wait();
        round(1, 0, 0, 1, 0, rand64());

        repeat (300)
            round($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 2),
                  $urandom_range(1, 4), $urandom_range(0, 7) == 0, rand64());
        for (int i = 0; i < 4; i++)
            if (lsu_pend || walk_pend) round(0, 0, 0, 1, 0, rand64());
        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        int       cyc;
        exp_req_t e;
        logic [63:0] x;
        cyc = 0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (done) break;
            if (cyc > 40000) begin
                $display("FAIL timeout: %0d cycles, stimulus never finished", cyc);
                n_err++;
                break;
            end
            if (reset || chk_zero) begin
                n_cmp++;
                if ({lsu_req_ready, lsu_resp_valid, lsu_resp_data, walk_resp_valid, walk_resp_data,
                     dc_req_valid, dc_req_addr, dc_req_write, dc_req_wdata, dc_req_phys, arb_owner} != '0) begin
                    n_err++;
                    $display("FAIL idle_zero @%0t: outputs not all 0 (dc_v=%b lsu_rv=%b walk_rv=%b rdy=%b own=%b addr=%h)",
                             $time, dc_req_valid, lsu_resp_valid, walk_resp_valid, lsu_req_ready, arb_owner, dc_req_addr);
                end
            end
            if (lsu_req_ready) begin
                n_cmp++;
                if (exp_rdy_q.size() == 0) begin
                    n_err++;
                    $display("FAIL lsu_ready @%0t: got ready=1, expected 0", $time);
                end else void'(exp_rdy_q.pop_front());
            end
            if (dc_req_valid && dc_req_ready) begin
                n_cmp++;
                if (exp_dc_q.size() == 0) begin
                    n_err++;
                    $display("FAIL dc_req @%0t: unexpected request addr=%h", $time, dc_req_addr);
                end else begin
                    e = exp_dc_q.pop_front();
                    if ({dc_req_addr, dc_req_write, dc_req_wdata, dc_req_phys, arb_owner} != {e, e.p}) begin
                        n_err++;
                        $display("FAIL dc_req @%0t: got a=%h w=%b d=%h phys=%b own=%b, expected a=%h w=%b d=%h phys=%b",
                                 $time, dc_req_addr, dc_req_write, dc_req_wdata, dc_req_phys, arb_owner,
                                 e.a, e.w, e.d, e.p);
                    end
                end
            end
            if (lsu_resp_valid) begin
                n_cmp++;
                if (exp_lsu_q.size() == 0) begin
                    n_err++;
                    $display("FAIL lsu_resp @%0t: unexpected pulse data=%h", $time, lsu_resp_data);
                end else begin
                    x = exp_lsu_q.pop_front();
                    if (lsu_resp_data != x) begin
                        n_err++;
                        $display("FAIL lsu_resp @%0t: got %h expected %h", $time, lsu_resp_data, x);
                    end
                end
            end
            if (walk_resp_valid) begin
                n_cmp++;
                if (exp_walk_q.size() == 0) begin
                    n_err++;
                    $display("FAIL walk_resp @%0t: unexpected pulse data=%h", $time, walk_resp_data);
                end else begin
                    x = exp_walk_q.pop_front();
                    if (walk_resp_data != x) begin
                        n_err++;
                        $display("FAIL walk_resp @%0t: got %h expected %h", $time, walk_resp_data, x);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_dc_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_dc: %0d requests never issued, expected 0", exp_dc_q.size());
        end
        n_cmp++;
        if (exp_lsu_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_lsu: %0d responses missing, expected 0", exp_lsu_q.size());
        end
        n_cmp++;
        if (exp_walk_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_walk: %0d responses missing, expected 0", exp_walk_q.size());
        end
        n_cmp++;
        if (exp_rdy_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_ready: %0d grants missing, expected 0", exp_rdy_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
